// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage: access FSM encoding
// and the word-address mask applied to data-memory addresses.
package memory_stage_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_e;

   localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/memory_stage_mem_wb_reg.sv
// MEM/WB pipeline register. Loads from the M side when enabled; when the
// stage is stalled it turns the W slot into a bubble (no write-back) and
// holds the data fields.
module mem_wb_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        regwrite_i,
   input  logic        isload_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] pcplus4_i,
   input  logic [31:0] aluresult_i,
   input  logic        rdata_upd_i,
   input  logic [31:0] rdata_i,
   output logic        regwrite_o,
   output logic        isload_o,
   output logic [4:0]  rd_o,
   output logic [31:0] pcplus4_o,
   output logic [31:0] aluresult_o,
   output logic [31:0] rdata_o
);

   logic        regwrite_q;
   logic        isload_q;
   logic [4:0]  rd_q;
   logic [31:0] pcplus4_q;
   logic [31:0] aluresult_q;
   logic [31:0] rdata_q;

   // Advance on enable, otherwise kill the write-back and hold the data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regwrite_q  <= 1'b0;
         isload_q    <= 1'b0;
         rd_q        <= '0;
         pcplus4_q   <= '0;
         aluresult_q <= '0;
         rdata_q     <= '0;
      end else if (en_i) begin
         regwrite_q  <= regwrite_i;
         isload_q    <= isload_i;
         rd_q        <= rd_i;
         pcplus4_q   <= pcplus4_i;
         aluresult_q <= aluresult_i;
         if (rdata_upd_i)
            rdata_q <= rdata_i;
      end else begin
         regwrite_q <= 1'b0;
         isload_q   <= 1'b0;
      end
   end

   assign regwrite_o  = regwrite_q;
   assign isload_o    = isload_q;
   assign rd_o        = rd_q;
   assign pcplus4_o   = pcplus4_q;
   assign aluresult_o = aluresult_q;
   assign rdata_o     = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: issues data-memory accesses over a req/ack port,
// stalls upstream while an access is outstanding, and owns the MEM/WB
// register feeding write-back and the Execute forwarding path.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned accesses
// (no request, write-back suppressed, misalignW raised). Without it the
// low address bits are simply dropped and misalignW is tied low.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        regwriteM,
   input  logic        memwriteM,
   input  logic        isloadM,
   input  logic        memreadM,
   input  logic [4:0]  rdM,
   input  logic [31:0] pcplus4M,
   input  logic [31:0] aluresultM,
   input  logic [31:0] writedataM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stallM,
   output logic        regwriteW,
   output logic        isloadW,
   output logic [4:0]  rdW,
   output logic [31:0] pcplus4W,
   output logic [31:0] aluresultW,
   output logic [31:0] readdataW,
   output logic [31:0] resultW,
   output logic        misalignW
);

   mem_state_e  state_q, state_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        access;
   logic        misalign;
   logic        go;
   logic        rdata_upd;

   assign access = memreadM | memwriteM;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = access & (aluresultM[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // A trapped misaligned access never reaches the memory port.
   assign go = access & ~misalign;

   // Upstream holds the M inputs during the stall, so they drive the port directly.
   assign dmem_we    = memwriteM;
   assign dmem_addr  = aluresultM & WORD_ADDR_MASK;
   assign dmem_wdata = writedataM;

   // Access FSM state and the read-data buffer captured on ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // Next state plus request/stall; ack only matters while waiting.
   always_comb begin
      state_d  = state_q;
      rbuf_d   = rbuf_q;
      dmem_req = 1'b0;
      stallM   = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (go) begin
               dmem_req = 1'b1;
               stallM   = 1'b1;
               state_d  = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            stallM   = 1'b1;
            if (dmem_ack) begin
               rbuf_d  = dmem_rdata;
               state_d = MEM_DONE;
            end
         end
         MEM_DONE: state_d = MEM_IDLE;
         default:  state_d = MEM_IDLE;
      endcase
      // Nothing leaves the stage while reset is held.
      if (rst) begin
         dmem_req = 1'b0;
         stallM   = 1'b0;
      end
   end

   // Only a completed pure read refreshes readdataW; that completion is DONE.
   assign rdata_upd = (state_q == MEM_DONE) & memreadM & ~memwriteM;

   mem_wb_reg u_mem_wb (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (~stallM),
      .regwrite_i  (regwriteM & ~misalign),
      .isload_i    (isloadM),
      .rd_i        (rdM),
      .pcplus4_i   (pcplus4M),
      .aluresult_i (aluresultM),
      .rdata_upd_i (rdata_upd),
      .rdata_i     (rbuf_q),
      .regwrite_o  (regwriteW),
      .isload_o    (isloadW),
      .rd_o        (rdW),
      .pcplus4_o   (pcplus4W),
      .aluresult_o (aluresultW),
      .rdata_o     (readdataW)
   );

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   // Misalign flag follows each non-stalled MEM/WB update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         misalign_q <= 1'b0;
      else if (!stallM)
         misalign_q <= misalign;
   end

   assign misalignW = misalign_q;
`else
   assign misalignW = 1'b0;
`endif

   assign resultW = isloadW ? readdataW : aluresultW;

endmodule
